// File: rtl/polyphase_pkg.sv
// polyphase_pkg: shared types and helpers for the polyphase interpolators.
//   fsm_t       - sequencer states (IDLE, MAC, DRAIN)
//   buf_depth() - sample buffer depth: power of two covering all taps + margin
//   wacc_w()    - exact accumulator width
//   round_sat() - round-half-up, arithmetic shift, saturate to wo bits
package polyphase_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MAC   = 2'd1,
      DRAIN = 2'd2
   } fsm_t;

   typedef struct packed {
      logic               sat;
      logic signed [63:0] val;
   } rs_t;

   function automatic int buf_depth(input int osf, input int taps);
      int need;
      int d;
      need = osf * taps + taps + 4;
      d    = 1;
      for (int i = 0; i < 31; i++) begin
         if (d < need) d = d * 2;
      end
      return d;
   endfunction

   function automatic int wacc_w(input int wiq, input int wc, input int taps);
      return wiq + wc + $clog2(taps) + 1;
   endfunction

   // acc must already be sign-extended to 64 bits; shift and wo are constants.
   function automatic rs_t round_sat(input logic signed [63:0] acc,
                                     input int shift, input int wo);
      logic signed [63:0] t;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      rs_t                r;
      t = acc;
      if (shift > 0) t = t + (64'sd1 <<< (shift - 1));
      t     = t >>> shift;
      hi    = (64'sd1 <<< (wo - 1)) - 64'sd1;
      lo    = -(64'sd1 <<< (wo - 1));
      r.sat = 1'b0;
      r.val = t;
      if (t > hi) begin
         r.val = hi;
         r.sat = 1'b1;
      end else if (t < lo) begin
         r.val = lo;
         r.sat = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/polyphase_coef_ram.sv
// polyphase_coef_ram: simple dual-port coefficient RAM, registered read.
//   clk      - clock
//   we_i     - write enable;  waddr_i / wdata_i - write port
//   raddr_i  - read address;  rdata_o - data one cycle later
// A same-address read and write in one cycle returns the old contents.
// Contents are not reset.
module polyphase_coef_ram #(
   parameter int DEPTH = 100,
   parameter int AW    = 7,
   parameter int WC    = 16
) (
   input  logic                 clk,
   input  logic                 we_i,
   input  logic [AW-1:0]        waddr_i,
   input  logic signed [WC-1:0] wdata_i,
   input  logic [AW-1:0]        raddr_i,
   output logic signed [WC-1:0] rdata_o
);

   logic signed [WC-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i && (int'(waddr_i) < DEPTH)) mem[waddr_i] <= wdata_i;
      rdata_o <= mem[raddr_i];
   end

endmodule

// File: rtl/polyphase_interp_pipe.sv
// polyphase_interp_pipe: polyphase fractional-delay interpolator, I/Q.
//   clk, rst_n                 - clock, async active-low reset
//   i_raw_i, q_raw_i, iq_raw_val_i - raw sample stream
//   phase_int_i, sym_valid_i   - branch select and symbol strobe
//   coef_we_i/addr_i/data_i    - coefficient bank write port
//   i_sym_o, q_sym_o, sym_valid_o, sat_o - rounded/saturated result
//   busy_o                     - MAC sequence running
//   drop_o                     - sticky: a strobe was discarded
//
// state | meaning
// IDLE  | waiting for an accepted strobe
// MAC   | issue one tap (buffer + coefficient address) per cycle
// DRAIN | two cycles for RAM read and product register, then emit
module polyphase_interp_pipe
   import polyphase_pkg::*;
#(
   parameter int OSF       = 20,
   parameter int TAPS_PPH  = 5,
   parameter int WIQ       = 16,
   parameter int WC        = 16,
   parameter int WO        = 18,
   parameter int OUT_SHIFT = 15
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic signed [WIQ-1:0]                 i_raw_i,
   input  logic signed [WIQ-1:0]                 q_raw_i,
   input  logic                                  iq_raw_val_i,
   input  logic [$clog2(OSF)-1:0]                phase_int_i,
   input  logic                                  sym_valid_i,
   input  logic                                  coef_we_i,
   input  logic [$clog2(OSF*TAPS_PPH)-1:0]       coef_addr_i,
   input  logic signed [WC-1:0]                  coef_data_i,
   output logic signed [WO-1:0]                  i_sym_o,
   output logic signed [WO-1:0]                  q_sym_o,
   output logic                                  sym_valid_o,
   output logic                                  sat_o,
   output logic                                  busy_o,
   output logic                                  drop_o
);

   localparam int NC   = OSF * TAPS_PPH;
   localparam int PW   = $clog2(OSF);
   localparam int AW   = $clog2(NC);
   localparam int BUF  = buf_depth(OSF, TAPS_PPH);
   localparam int BW   = $clog2(BUF);
   localparam int FW   = $clog2(NC + 1);
   localparam int TW   = $clog2(TAPS_PPH) + 1;
   localparam int WP   = WIQ + WC;
   localparam int WACC = wacc_w(WIQ, WC, TAPS_PPH);

   fsm_t                   state_q, state_d;
   logic [TW-1:0]          cnt_q, cnt_d;
   logic [BW-1:0]          wp_q;
   logic [FW-1:0]          fill_q, fill_d, fill_cap_q;
   logic [BW-1:0]          base_q;
   logic [PW-1:0]          phase_q;
   logic                   tap_ok_q, rd_vld_q, prod_vld_q;
   logic signed [WIQ-1:0]  i_rd_q, q_rd_q;
   logic signed [WP-1:0]   prod_i_q, prod_q_q;
   logic signed [WACC-1:0] acc_i_q, acc_q_q, sum_i, sum_q;
   logic signed [WC-1:0]   coef_rd;
   logic signed [WIQ-1:0]  ibuf [BUF];
   logic signed [WIQ-1:0]  qbuf [BUF];

   logic                   strobe, accept, emit, age_ok;
   logic [AW-1:0]          age, coef_raddr;
   logic [BW-1:0]          rd_idx;
   rs_t                    rs_i, rs_q;

   assign strobe = sym_valid_i && iq_raw_val_i;
   assign accept = strobe && (state_q == IDLE) && (int'(phase_int_i) < OSF);
   assign emit   = (state_q == DRAIN) && (cnt_q == TW'(1));
   assign busy_o = (state_q != IDLE);

   // Fill includes the sample written this cycle, so the strobe sample is age 0.
   assign fill_d = (iq_raw_val_i && (int'(fill_q) != NC)) ? fill_q + FW'(1) : fill_q;

   assign age        = AW'(cnt_q) * AW'(OSF) + AW'(phase_q);
   assign coef_raddr = AW'(phase_q) * AW'(TAPS_PPH) + AW'(cnt_q);
   assign rd_idx     = base_q - BW'(age);
   assign age_ok     = int'(age) < int'(fill_cap_q);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (accept) state_d = MAC;
         end
         MAC: begin
            if (cnt_q == TW'(TAPS_PPH - 1)) begin
               state_d = DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end
         DRAIN: begin
            if (cnt_q == TW'(1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   polyphase_coef_ram #(.DEPTH(NC), .AW(AW), .WC(WC)) u_coef (
      .clk     (clk),
      .we_i    (coef_we_i),
      .waddr_i (coef_addr_i),
      .wdata_i (coef_data_i),
      .raddr_i (coef_raddr),
      .rdata_o (coef_rd)
   );

   // Sample buffer and its registered read port; not reset.
   always_ff @(posedge clk) begin
      if (iq_raw_val_i) begin
         ibuf[wp_q] <= i_raw_i;
         qbuf[wp_q] <= q_raw_i;
      end
      i_rd_q <= ibuf[rd_idx];
      q_rd_q <= qbuf[rd_idx];
   end

   assign sum_i = acc_i_q + WACC'(prod_i_q);
   assign sum_q = acc_q_q + WACC'(prod_q_q);
   assign rs_i  = round_sat(64'(sum_i), OUT_SHIFT, WO);
   assign rs_q  = round_sat(64'(sum_q), OUT_SHIFT, WO);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         wp_q        <= '0;
         fill_q      <= '0;
         fill_cap_q  <= '0;
         base_q      <= '0;
         phase_q     <= '0;
         tap_ok_q    <= 1'b0;
         rd_vld_q    <= 1'b0;
         prod_vld_q  <= 1'b0;
         prod_i_q    <= '0;
         prod_q_q    <= '0;
         acc_i_q     <= '0;
         acc_q_q     <= '0;
         i_sym_o     <= '0;
         q_sym_o     <= '0;
         sym_valid_o <= 1'b0;
         sat_o       <= 1'b0;
         drop_o      <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fill_q  <= fill_d;
         if (iq_raw_val_i) wp_q <= wp_q + BW'(1);
         if (accept) begin
            base_q     <= wp_q;
            phase_q    <= phase_int_i;
            fill_cap_q <= fill_d;
         end
         if (strobe && !accept) drop_o <= 1'b1;

         rd_vld_q   <= (state_q == MAC);
         tap_ok_q   <= (state_q == MAC) && age_ok;
         prod_vld_q <= rd_vld_q;
         // Taps older than the fill count contribute zero.
         prod_i_q   <= tap_ok_q ? $signed({{WC{i_rd_q[WIQ-1]}}, i_rd_q}) *
                                  $signed({{WIQ{coef_rd[WC-1]}}, coef_rd}) : '0;
         prod_q_q   <= tap_ok_q ? $signed({{WC{q_rd_q[WIQ-1]}}, q_rd_q}) *
                                  $signed({{WIQ{coef_rd[WC-1]}}, coef_rd}) : '0;

         if (accept) begin
            acc_i_q <= '0;
            acc_q_q <= '0;
         end else if (prod_vld_q) begin
            acc_i_q <= sum_i;
            acc_q_q <= sum_q;
         end

         sym_valid_o <= emit;
         sat_o       <= emit && (rs_i.sat || rs_q.sat);
         if (emit) begin
            i_sym_o <= rs_i.val[WO-1:0];
            q_sym_o <= rs_q.val[WO-1:0];
         end
      end
   end

endmodule

// File: tb/tb_polyphase_interp_pipe.sv
module tb_polyphase_interp_pipe;

   logic               clk = 1'b0;
   logic               rst_n;
   logic signed [15:0] i_raw_i, q_raw_i;
   logic               iq_raw_val_i;
   logic [4:0]         phase_int_i;
   logic               sym_valid_i;
   logic               coef_we_i;
   logic [6:0]         coef_addr_i;
   logic signed [15:0] coef_data_i;
   logic signed [17:0] i_sym_o, q_sym_o;
   logic               sym_valid_o, sat_o, busy_o, drop_o;

   int     n_cmp = 0;
   int     n_err = 0;
   int     cyc_cnt = 0;
   int     strobe_cyc = 0;
   int     nvalid = 0;
   int     cap_cyc = 0;
   longint cap_i, cap_q;
   logic   cap_sat;
   int     nv0;

   polyphase_interp_pipe dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_raw_i      (i_raw_i),
      .q_raw_i      (q_raw_i),
      .iq_raw_val_i (iq_raw_val_i),
      .phase_int_i  (phase_int_i),
      .sym_valid_i  (sym_valid_i),
      .coef_we_i    (coef_we_i),
      .coef_addr_i  (coef_addr_i),
      .coef_data_i  (coef_data_i),
      .i_sym_o      (i_sym_o),
      .q_sym_o      (q_sym_o),
      .sym_valid_o  (sym_valid_o),
      .sat_o        (sat_o),
      .busy_o       (busy_o),
      .drop_o       (drop_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt++;

   always @(negedge clk) begin
      if (sym_valid_o) begin
         nvalid++;
         cap_cyc = cyc_cnt;
         cap_i   = longint'(i_sym_o);
         cap_q   = longint'(q_sym_o);
         cap_sat = sat_o;
      end
   end

   task automatic check(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      iq_raw_val_i = 1'b0;
      sym_valid_i  = 1'b0;
      coef_we_i    = 1'b0;
      i_raw_i      = '0;
      q_raw_i      = '0;
      phase_int_i  = '0;
      coef_addr_i  = '0;
      coef_data_i  = '0;
      idle(3);
      rst_n = 1'b1;
      step();
   endtask

   // only < 0: every entry gets val; otherwise only that address, rest 0.
   task automatic load_coefs(input int val, input int only);
      for (int a = 0; a < 100; a++) begin
         coef_we_i   = 1'b1;
         coef_addr_i = 7'(a);
         coef_data_i = ((only < 0) || (a == only)) ? 16'(val) : 16'sd0;
         step();
      end
      coef_we_i = 1'b0;
   endtask

   task automatic push(input int iv, input int qv, input bit stb, input int ph);
      i_raw_i      = 16'(iv);
      q_raw_i      = 16'(qv);
      iq_raw_val_i = 1'b1;
      sym_valid_i  = stb;
      phase_int_i  = 5'(ph);
      if (stb) strobe_cyc = cyc_cnt;
      step();
      iq_raw_val_i = 1'b0;
      sym_valid_i  = 1'b0;
   endtask

   task automatic fill_and_strobe(input int n, input int iv, input int qv, input int ph);
      for (int k = 0; k < n - 1; k++) push(iv, qv, 1'b0, 0);
      push(iv, qv, 1'b1, ph);
   endtask

   initial begin
      do_reset();
      check("rst_i", longint'(i_sym_o), 0);
      check("rst_q", longint'(q_sym_o), 0);
      check("rst_valid", longint'(sym_valid_o), 0);
      check("rst_sat", longint'(sat_o), 0);
      check("rst_busy", longint'(busy_o), 0);
      check("rst_drop", longint'(drop_o), 0);

      // Constant input: 5 * 16384*16384 >> 15 = 40960.
      load_coefs(16384, -1);
      nv0 = nvalid;
      fill_and_strobe(120, 16384, 16384, 0);
      check("const_busy", longint'(busy_o), 1);
      idle(12);
      check("const_nvalid", longint'(nvalid - nv0), 1);
      check("const_i", cap_i, 40960);
      check("const_q", cap_q, 40960);
      check("const_sat", longint'(cap_sat), 0);
      check("const_latency", longint'(cap_cyc - strobe_cyc), 8);
      check("const_hold_i", longint'(i_sym_o), 40960);
      check("const_busy_end", longint'(busy_o), 0);
      check("const_drop", longint'(drop_o), 0);

      // Saturation both directions.
      load_coefs(32767, -1);
      nv0 = nvalid;
      fill_and_strobe(120, 32767, -32768, 0);
      idle(12);
      check("sat_nvalid", longint'(nvalid - nv0), 1);
      check("sat_i", cap_i, 131071);
      check("sat_q", cap_q, -131072);
      check("sat_flag", longint'(cap_sat), 1);
      check("sat_pulse", longint'(sat_o), 0);

      // Phase/tap select: coef[7*5+2], age 47 -> sample 152 -> 76 / -76.
      load_coefs(16384, 37);
      nv0 = nvalid;
      for (int n = 0; n < 199; n++) push(n, -n, 1'b0, 0);
      push(199, -199, 1'b1, 7);
      idle(12);
      check("sel_nvalid", longint'(nvalid - nv0), 1);
      check("sel_i", cap_i, 76);
      check("sel_q", cap_q, -76);
      check("sel_sat", longint'(cap_sat), 0);

      // Fill after reset: only age 0 valid -> 500 / -500.
      do_reset();
      load_coefs(16384, -1);
      nv0 = nvalid;
      fill_and_strobe(10, 1000, -1000, 0);
      idle(12);
      check("fill_nvalid", longint'(nvalid - nv0), 1);
      check("fill_i", cap_i, 500);
      check("fill_q", cap_q, -500);
      check("fill_latency", longint'(cap_cyc - strobe_cyc), 8);

      // Strobe 3 cycles after an accepted one is dropped.
      nv0 = nvalid;
      push(1000, -1000, 1'b1, 0);
      push(1000, -1000, 1'b0, 0);
      push(1000, -1000, 1'b0, 0);
      push(1000, -1000, 1'b1, 0);
      idle(12);
      check("busy_drop_nvalid", longint'(nvalid - nv0), 1);
      check("busy_drop_flag", longint'(drop_o), 1);

      // Out-of-range phase after reset.
      do_reset();
      check("ph_drop_clear", longint'(drop_o), 0);
      nv0 = nvalid;
      push(5, 5, 1'b1, 25);
      check("ph_busy", longint'(busy_o), 0);
      idle(12);
      check("ph_nvalid", longint'(nvalid - nv0), 0);
      check("ph_drop", longint'(drop_o), 1);

      // Reset two cycles after an accepted strobe aborts the sequence.
      do_reset();
      nv0 = nvalid;
      fill_and_strobe(120, 16384, 16384, 0);
      step();
      rst_n = 1'b0;
      #1;
      check("abort_i", longint'(i_sym_o), 0);
      check("abort_busy", longint'(busy_o), 0);
      check("abort_drop", longint'(drop_o), 0);
      idle(2);
      rst_n = 1'b1;
      idle(12);
      check("abort_nvalid", longint'(nvalid - nv0), 0);

      // Back-to-back at minimum spacing (8 cycles), both accepted.
      nv0 = nvalid;
      fill_and_strobe(120, 16384, 16384, 0);
      for (int k = 0; k < 7; k++) push(16384, 16384, 1'b0, 0);
      push(16384, 16384, 1'b1, 0);
      idle(12);
      check("b2b_nvalid", longint'(nvalid - nv0), 2);
      check("b2b_i", cap_i, 40960);
      check("b2b_q", cap_q, 40960);
      check("b2b_latency", longint'(cap_cyc - strobe_cyc), 8);
      check("b2b_drop", longint'(drop_o), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/polyphase_interp_pipe.md
# polyphase_interp_pipe

Synthesizable, parametrised successor to the polyphase fractional-delay interpolator in the MSK receiver timing-recovery path. It sits between the raw I/Q sample stream and the symbol slicer. On each symbol strobe it computes a TAPS_PPH-tap dot product using a per-phase, per-tap, run-time loadable coefficient bank, which enables pulse-shaped interpolation. One time-multiplexed MAC per channel is shared across the taps, and the output is rounded and saturated.

## Interface
- OSF, 20: polyphase branches (samples/symbol).
- TAPS_PPH, 5: taps per branch.
- WIQ, 16: signed input sample width.
- WC, 16: signed coefficient width.
- WO, 18: signed output width.
- OUT_SHIFT, 15: right shift applied to the accumulator before saturation.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_raw_i, q_raw_i  in  WIQ  raw samples.
- iq_raw_val_i  in  1  sample valid.
- phase_int_i  in  $clog2(OSF)  branch select, sampled with the strobe.
- sym_valid_i  in  1  symbol strobe; honoured only when iq_raw_val_i is also high.
- coef_we_i  in  1  coefficient write enable.
- coef_addr_i  in  $clog2(OSF*TAPS_PPH)  coefficient address = phase*TAPS_PPH + k.
- coef_data_i  in  WC  coefficient value.
- i_sym_o, q_sym_o  out  WO  interpolated symbol.
- sym_valid_o  out  1  one-cycle output strobe.
- sat_o  out  1  set with sym_valid_o if either channel saturated.
- busy_o  out  1  a MAC sequence is in progress.
- drop_o  out  1  sticky flag: a strobe was discarded; cleared only by reset.

## Operation
- **Sample buffer:** circular buffer, depth BUF = smallest power of two ≥ OSF*TAPS_PPH + TAPS_PPH + 4, with write pointer wp. Each valid sample is written at wp and wp increments, wrapping modulo BUF. The buffer is not reset.
- **Fill counter:** saturates at OSF*TAPS_PPH and is cleared by reset. A tap whose age is ≥ the fill count reads as 0.
- **Age:** the sample written in the strobe cycle is age 0. Tap k of phase p reads age k*OSF + p.
- **Strobe capture:** an accepted strobe latches wp and phase. Samples arriving during MAC never overwrite an addressed sample, which is guaranteed by the BUF margin.
- **FSM:**
  - IDLE: on an accepted strobe, go to MAC.
  - MAC: TAPS_PPH cycles, issuing one tap address per cycle; then go to DRAIN.
  - DRAIN: 2 cycles covering the RAM read and product register; then go to IDLE and emit the result.
- **Strobe rejection:** a strobe is discarded and drop_o is set in either case:
  - it arrives while busy_o is high;
  - phase_int_i ≥ OSF.
- **Arithmetic:**
  - Products are WIQ+WC bits.
  - The accumulator is WACC = WIQ+WC+$clog2(TAPS_PPH)+1 bits and is exact.
  - Result = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT; no rounding term is added when OUT_SHIFT = 0.
  - The result saturates to [-2^(WO-1), 2^(WO-1)-1].
- **Coefficients:** writes are accepted in any cycle. A read of the same address in the same cycle returns the old value. Coefficient contents are undefined after power-up and are not reset; software loads all OSF*TAPS_PPH entries before the first strobe.
- **Output hold:** i_sym_o and q_sym_o hold their value between strobes.

## Timing
- **Reset values:** all outputs 0, FSM IDLE, wp 0, fill 0.
- **Reset mid-sequence:** aborts with no sym_valid_o.
- **Accepted strobe at cycle S:**
  - busy_o is high for cycles S+1 … S+TAPS_PPH+2.
  - sym_valid_o, result and sat_o appear at cycle S+TAPS_PPH+3, a latency of 8 cycles with the defaults.
- **Back-to-back strobes:** a strobe in cycle S+TAPS_PPH+3 is accepted, since busy_o is low in that cycle. Minimum strobe spacing is TAPS_PPH+3.
- **Concurrent input:** sample writes continue every cycle regardless of FSM state.

## Structure
- **Package polyphase_pkg:**
  - FSM enum (IDLE, MAC, DRAIN);
  - functions for BUF depth and WACC;
  - a round/saturate function shared with future interpolators.
- **Sub-module polyphase_coef_ram:** simple dual-port RAM, OSF*TAPS_PPH × WC, registered read with 1-cycle latency.
- **Top level:** the I/Q sample buffer, FSM and the two MAC datapaths.

## Test plan
Defaults for all scenarios; OUT_SHIFT = 15.
- **Constant input:** all coefficients 16384, 120 samples of 16384, strobe with phase 0 → i/q = 40960, sat_o = 0, sym_valid_o exactly 8 cycles after the strobe.
- **Saturation:** all coefficients 32767; input i = 32767, q = -32768, 120 samples → i = 131071, q = -131072, sat_o = 1.
- **Phase/tap select:** only coefficient [p=7][k=2] = 16384, all others 0; sample value n for n = 0…199; strobe on n = 199, phase 7 → output 76 (age 47 → sample 152).
- **Fill after reset:** all coefficients 16384; 10 samples of 1000, strobe with phase 0 → output 500 (only age 0 is valid).
- **Drops:**
  - a strobe 3 cycles after an accepted one → a single sym_valid_o and drop_o = 1;
  - after reset, a strobe with phase 25 → no output and drop_o = 1.
- **Reset mid-MAC:** drop rst_n 2 cycles after a strobe → all outputs 0 and no sym_valid_o; a new strobe after reset is processed normally.
